// File: rtl/uart_pkg.sv
// Shared definitions for the UART block sequencer: FSM state encoding,
// block geometry and the big-endian byte-lane helper.
package uart_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_BITS  = 128;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        SEND    = 2'd3
    } ctrl_state_e;

    // Byte k sits at [127-8k -: 8], so its LSB is 8*(15-k) = {~k, 3'b000}.
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        return {~idx, 3'b000};
    endfunction

endpackage

// File: rtl/uart_block_ctrl_if.sv
// Bundle of the FIFO-side and engine-side signals of uart_block_ctrl.
// master = the sequencer, slave = FIFOs, engine and status observers.
interface uart_block_ctrl_if;
    import uart_pkg::*;

    logic                  rx_empty;
    logic [7:0]            read_data;
    logic                  read_uart;
    logic                  tx_full;
    logic                  write_uart;
    logic [7:0]            write_data;
    logic                  eng_start;
    logic [BLOCK_BITS-1:0] eng_in;
    logic                  eng_done;
    logic [BLOCK_BITS-1:0] eng_out;
    logic                  busy;
    logic                  drop;
    logic [15:0]           block_count;

    modport master (
        input  rx_empty, read_data, tx_full, eng_done, eng_out,
        output read_uart, write_uart, write_data, eng_start, eng_in,
               busy, drop, block_count
    );

    modport slave (
        output rx_empty, read_data, tx_full, eng_done, eng_out,
        input  read_uart, write_uart, write_data, eng_start, eng_in,
               busy, drop, block_count
    );

endinterface

// File: rtl/uart_block_ctrl.sv
// Packs 16 RX bytes into a block, runs it through the block engine and
// streams the 16 result bytes to the TX FIFO; stale partial blocks are dropped.
module uart_block_ctrl
    import uart_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_BITS = 20
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    uart_block_ctrl_if.master   bus
);

    localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

    ctrl_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [BLOCK_BITS-1:0] pack_q, pack_d;
    logic [BLOCK_BITS-1:0] result_q, result_d;
    logic [TO_BITS-1:0]    idle_q, idle_d;
    logic                  busy_q, busy_d;
    logic [15:0]           block_count_q, block_count_d;

    logic rx_pop;
    logic tx_push;
    logic idle_expired;

    assign rx_pop       = (state_q == COLLECT) && !bus.rx_empty;
    assign tx_push      = (state_q == SEND) && !bus.tx_full;
    assign idle_expired = (state_q == COLLECT) && bus.rx_empty && (cnt_q != 4'd0)
                          && (idle_q == TO_BITS'(TIMEOUT - 1));

    assign bus.read_uart   = rx_pop;
    assign bus.write_uart  = tx_push;
    assign bus.drop        = idle_expired;
    assign bus.eng_start   = (state_q == START);
    assign bus.write_data  = (state_q == SEND) ? result_q[byte_lsb(cnt_q) +: DBITS] : '0;
    assign bus.eng_in      = pack_q;
    assign bus.busy        = busy_q;
    assign bus.block_count = block_count_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        pack_d        = pack_q;
        result_d      = result_q;
        idle_d        = idle_q;
        block_count_d = block_count_q;

        unique case (state_q)
            COLLECT: begin
                if (rx_pop) begin
                    pack_d[byte_lsb(cnt_q) +: DBITS] = bus.read_data;
                    cnt_d  = (cnt_q == LAST_IDX) ? 4'd0 : cnt_q + 4'd1;
                    idle_d = '0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = START;
                    end
                end else if (idle_expired) begin
                    cnt_d  = 4'd0;
                    idle_d = '0;
                end else if (cnt_q != 4'd0) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Only WAIT listens to eng_done; stray pulses elsewhere are harmless.
                if (bus.eng_done) begin
                    result_d = bus.eng_out;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (tx_push) begin
                    cnt_d = (cnt_q == LAST_IDX) ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        block_count_d = block_count_q + 16'd1;
                        state_d       = COLLECT;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        busy_d = (state_d != COLLECT);
    end

    // NOTE: the 128-bit pack and result registers are reset too, because
    // eng_in must read 0 out of reset and they are plain flops, not a RAM.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q       <= COLLECT;
            cnt_q         <= 4'd0;
            pack_q        <= '0;
            result_q      <= '0;
            idle_q        <= '0;
            busy_q        <= 1'b0;
            block_count_q <= 16'd0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pack_q        <= pack_d;
            result_q      <= result_d;
            idle_q        <= idle_d;
            busy_q        <= busy_d;
            block_count_q <= block_count_d;
        end
    end

endmodule

// File: tb/tb_uart_block_ctrl.sv
// Self-checking bench for uart_block_ctrl: RX/TX FIFO and engine models,
// a block-level reference model compared every cycle, plus directed literals.
module tb_uart_block_ctrl;

    localparam int TIMEOUT = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_block_ctrl_if bus();

    uart_block_ctrl #(.DBITS(8), .TIMEOUT(TIMEOUT), .TO_BITS(6)) dut (
        .clk_100MHz (clk),
        .reset      (rst_n),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus controls shared with the environment process.
    logic [7:0]   rxq[$];
    logic         tx_full_req = 1'b0;
    int           eng_lat     = 5;
    logic [127:0] eng_xor     = '0;
    logic         spur_req    = 1'b0;

    // Observations.
    int           cyc = 0, pushes = 0, starts = 0, drops = 0, pops_busy = 0;
    int           last_pop_cyc = 0, drop_cyc = 0, first_pop_cyc = -1, last_push_cyc = 0;
    logic [127:0] start_blk = '0;
    logic [7:0]   tx_log[$];

    // Block-level reference model.
    logic [7:0]   m_rx[$];
    logic [7:0]   m_tx[$];
    logic [127:0] m_blk;
    logic         m_busy, m_start, m_wait, m_send;
    int           m_last_pop, m_blocks;

    task automatic model_reset();
        m_rx.delete();
        m_tx.delete();
        m_blk      = '0;
        m_busy     = 1'b0;
        m_start    = 1'b0;
        m_wait     = 1'b0;
        m_send     = 1'b0;
        m_last_pop = 0;
        m_blocks   = 0;
    endtask

    initial begin : env
        logic pop_now, start_now, exp_read, exp_start, exp_drop, exp_write;
        int   eng_cd;
        bus.rx_empty  = 1'b1;
        bus.read_data = 8'h00;
        bus.tx_full   = 1'b0;
        bus.eng_done  = 1'b0;
        bus.eng_out   = '0;
        eng_cd        = 0;
        model_reset();
        forever begin
            @(negedge clk);
            pop_now   = 1'b0;
            start_now = 1'b0;
            if (!rst_n) begin
                model_reset();
            end else begin
                exp_read  = !m_busy && !bus.rx_empty;
                exp_start = m_start;
                exp_drop  = !m_busy && (m_rx.size() > 0) && bus.rx_empty
                            && (cyc - m_last_pop == TIMEOUT);
                exp_write = m_send && !bus.tx_full;

                check("read_uart",   128'(bus.read_uart),   128'(exp_read));
                check("eng_start",   128'(bus.eng_start),   128'(exp_start));
                check("drop",        128'(bus.drop),        128'(exp_drop));
                check("write_uart",  128'(bus.write_uart),  128'(exp_write));
                check("busy",        128'(bus.busy),        128'(m_busy));
                check("block_count", 128'(bus.block_count), 128'(16'(m_blocks)));
                if (bus.write_uart && exp_write)
                    check("write_data", 128'(bus.write_data), 128'(m_tx[0]));
                if (m_busy && !m_send)
                    check("eng_in", bus.eng_in, m_blk);

                if (bus.read_uart) begin
                    pop_now      = 1'b1;
                    last_pop_cyc = cyc;
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    if (bus.busy) pops_busy++;
                end
                if (bus.drop) begin
                    drops++;
                    drop_cyc = cyc;
                end
                if (bus.eng_start) begin
                    starts++;
                    start_now = 1'b1;
                    start_blk = bus.eng_in;
                end
                if (bus.write_uart) begin
                    pushes++;
                    last_push_cyc = cyc;
                    tx_log.push_back(bus.write_data);
                end

                // Advance the model to the next cycle.
                m_start = 1'b0;
                if (exp_read) begin
                    m_rx.push_back(bus.read_data);
                    m_last_pop = cyc;
                    if (m_rx.size() == 16) begin
                        for (int k = 0; k < 16; k++) m_blk[127-8*k -: 8] = m_rx[k];
                        m_rx.delete();
                        m_busy  = 1'b1;
                        m_start = 1'b1;
                    end
                end
                if (exp_drop) m_rx.delete();
                if (m_wait && bus.eng_done) begin
                    for (int k = 0; k < 16; k++) m_tx.push_back(bus.eng_out[127-8*k -: 8]);
                    m_wait = 1'b0;
                    m_send = 1'b1;
                end else if (exp_write) begin
                    void'(m_tx.pop_front());
                    if (m_tx.size() == 0) begin
                        m_send = 1'b0;
                        m_busy = 1'b0;
                        m_blocks++;
                    end
                end
                if (exp_start) m_wait = 1'b1;
            end
            cyc++;

            @(posedge clk);
            #1;
            if (pop_now && rxq.size() > 0) void'(rxq.pop_front());
            bus.rx_empty  = (rxq.size() == 0);
            bus.read_data = (rxq.size() == 0) ? 8'h00 : rxq[0];
            bus.tx_full   = tx_full_req;
            bus.eng_done  = 1'b0;
            if (!rst_n) eng_cd = 0;
            else if (start_now) eng_cd = eng_lat;
            if (eng_cd > 0) begin
                eng_cd--;
                if (eng_cd == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_out  = bus.eng_in ^ eng_xor;
                end
            end else if (spur_req) begin
                bus.eng_done = 1'b1;
                bus.eng_out  = {4{32'hdeadbeef}};
                spur_req     = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_blocks(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && m_blocks < n; i++) step(1);
        check({tag, "_timeout"}, 128'(m_blocks >= n), 128'(1));
        step(1);
    endtask

    task automatic push_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) rxq.push_back(base + 8'(i));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_uart"},   128'(bus.read_uart),   128'(0));
        check({tag, "_write_uart"},  128'(bus.write_uart),  128'(0));
        check({tag, "_write_data"},  128'(bus.write_data),  128'(0));
        check({tag, "_eng_start"},   128'(bus.eng_start),   128'(0));
        check({tag, "_eng_in"},      bus.eng_in,            128'(0));
        check({tag, "_busy"},        128'(bus.busy),        128'(0));
        check({tag, "_drop"},        128'(bus.drop),        128'(0));
        check({tag, "_block_count"}, 128'(bus.block_count), 128'(0));
    endtask

    function automatic logic [127:0] tx_packed(input int first);
        logic [127:0] v = '0;
        for (int k = 0; k < 16; k++)
            if (first + k < tx_log.size()) v[127-8*k -: 8] = tx_log[first + k];
        return v;
    endfunction

    initial begin : main
        rst_n = 1'b0;
        step(3);
        check_all_zero("rst");
        rst_n = 1'b1;
        step(2);

        // Bytes 0x00..0x0F back-to-back, engine echoes after 5 cycles.
        eng_lat = 5;
        eng_xor = '0;
        first_pop_cyc = -1;
        push_bytes(8'h00, 16);
        wait_blocks(1, 300, "echo");
        check("echo_starts", 128'(starts), 128'(1));
        check("echo_eng_in", start_blk, 128'h000102030405060708090a0b0c0d0e0f);
        check("echo_tx_cnt", 128'(tx_log.size()), 128'(16));
        check("echo_tx",     tx_packed(0), 128'h000102030405060708090a0b0c0d0e0f);
        check("echo_bc",     128'(bus.block_count), 128'(1));
        check("echo_span",   128'(last_push_cyc - first_pop_cyc + 1), 128'(38));

        // tx_full held high for 3 cycles in the middle of SEND.
        eng_xor = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        pushes  = 0;
        tx_log.delete();
        push_bytes(8'h10, 16);
        for (int i = 0; i < 300 && pushes < 4; i++) step(1);
        check("full_reach4", 128'(pushes >= 4), 128'(1));
        tx_full_req = 1'b1;
        step(3);
        tx_full_req = 1'b0;
        wait_blocks(2, 300, "full");
        check("full_pushes", 128'(pushes), 128'(16));
        check("full_tx",     tx_packed(0), 128'h1f0f3f2f5f4f7f6f9f8fbfafdfcfffef);
        check("full_bc",     128'(bus.block_count), 128'(2));

        // Five bytes then idle: partial block must be dropped after TIMEOUT.
        drops = 0;
        push_bytes(8'h40, 5);
        for (int i = 0; i < 300 && drops == 0; i++) step(1);
        check("drop_seen",  128'(drops), 128'(1));
        check("drop_delay", 128'(drop_cyc - last_pop_cyc), 128'(50));
        check("drop_bc",    128'(bus.block_count), 128'(2));
        check("drop_busy",  128'(bus.busy), 128'(0));
        push_bytes(8'h80, 16);
        wait_blocks(3, 300, "after_drop");
        check("after_drop_eng_in", start_blk, 128'h808182838485868788898a8b8c8d8e8f);
        check("after_drop_bc",     128'(bus.block_count), 128'(3));
        check("after_drop_drops",  128'(drops), 128'(1));

        // 32 bytes queued while the engine stalls for 100 cycles.
        eng_lat   = 100;
        eng_xor   = '0;
        starts    = 0;
        pops_busy = 0;
        tx_log.delete();
        push_bytes(8'ha0, 32);
        wait_blocks(5, 1500, "stall");
        check("stall_starts",  128'(starts), 128'(2));
        check("stall_nopops",  128'(pops_busy), 128'(0));
        check("stall_eng_in2", start_blk, 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf);
        check("stall_tx1",     tx_packed(0), 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        check("stall_tx2",     tx_packed(16), 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf);
        check("stall_bc",      128'(bus.block_count), 128'(5));

        // Spurious eng_done while collecting, idle and mid-block.
        eng_lat  = 4;
        starts   = 0;
        spur_req = 1'b1;
        step(3);
        check("spur_idle_busy",   128'(bus.busy), 128'(0));
        check("spur_idle_starts", 128'(starts), 128'(0));
        push_bytes(8'he0, 3);
        step(4);
        spur_req = 1'b1;
        step(3);
        check("spur_part_busy", 128'(bus.busy), 128'(0));
        push_bytes(8'he3, 13);
        wait_blocks(6, 300, "spur");
        check("spur_eng_in", start_blk, 128'he0e1e2e3e4e5e6e7e8e9eaebecedeeef);
        check("spur_bc",     128'(bus.block_count), 128'(6));

        // Reset in the middle of SEND after 7 pushes.
        eng_lat = 3;
        pushes  = 0;
        push_bytes(8'h30, 16);
        for (int i = 0; i < 300 && pushes < 7; i++) step(1);
        check("mid_reach7", 128'(pushes), 128'(7));
        rst_n = 1'b0;
        #1;
        check_all_zero("mid");
        step(2);
        check("mid_no_push", 128'(pushes), 128'(7));
        rxq.delete();
        step(1);
        rst_n = 1'b1;
        step(2);
        starts = 0;
        tx_log.delete();
        push_bytes(8'hc0, 16);
        wait_blocks(1, 300, "post_rst");
        check("post_rst_starts", 128'(starts), 128'(1));
        check("post_rst_eng_in", start_blk, 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
        check("post_rst_tx",     tx_packed(0), 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
        check("post_rst_bc",     128'(bus.block_count), 128'(1));

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
